// File: rtl/aes_pkg.sv
// aes_pkg: shared AES datapath definitions.
//   - aes_state_t / aes_word_t : 128-bit state and 32-bit column types
//   - AES_POLY                 : low byte of the GF(2^8) reduction polynomial 0x11B
//   - xtime, gf_mul09/0b/0d/0e : constant multiplies used by InvMixColumns
package aes_pkg;

  typedef logic [127:0] aes_state_t;
  typedef logic [31:0]  aes_word_t;
  typedef logic [7:0]   aes_byte_t;

  localparam aes_byte_t AES_POLY = 8'h1B;

  // Multiply by x (0x02), reducing when the top bit shifts out.
  function automatic aes_byte_t xtime(input aes_byte_t x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic aes_byte_t gf_mul09(input aes_byte_t x);
    aes_byte_t x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x;
  endfunction

  function automatic aes_byte_t gf_mul0b(input aes_byte_t x);
    aes_byte_t x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ x;
  endfunction

  function automatic aes_byte_t gf_mul0d(input aes_byte_t x);
    aes_byte_t x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x;
  endfunction

  function automatic aes_byte_t gf_mul0e(input aes_byte_t x);
    aes_byte_t x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/inv_mix_col_word.sv
// inv_mix_col_word: combinational InvMixColumns of one 32-bit column.
//   col_i : column in, row 0 in [31:24]
//   col_o : column out, same layout
module inv_mix_col_word
  import aes_pkg::*;
(
  input  aes_word_t col_i,
  output aes_word_t col_o
);

  aes_byte_t a0, a1, a2, a3;

  assign a0 = col_i[31:24];
  assign a1 = col_i[23:16];
  assign a2 = col_i[15:8];
  assign a3 = col_i[7:0];

  // Circulant rows of [0e 0b 0d 09]
  assign col_o[31:24] = gf_mul0e(a0) ^ gf_mul0b(a1) ^ gf_mul0d(a2) ^ gf_mul09(a3);
  assign col_o[23:16] = gf_mul09(a0) ^ gf_mul0e(a1) ^ gf_mul0b(a2) ^ gf_mul0d(a3);
  assign col_o[15:8]  = gf_mul0d(a0) ^ gf_mul09(a1) ^ gf_mul0e(a2) ^ gf_mul0b(a3);
  assign col_o[7:0]   = gf_mul0b(a0) ^ gf_mul0d(a1) ^ gf_mul09(a2) ^ gf_mul0e(a3);

endmodule

// File: rtl/aes_inv_mix_cols.sv
// aes_inv_mix_cols: registered AES InvMixColumns stage, 1 state/clk, 1-cycle latency.
//   clk, rst_n : clock, async active-low reset (clears outputs immediately)
//   in_valid   : state valid this cycle
//   state      : 128-bit state, column-major, byte 0 at [127:120]
//   out_valid  : mixed valid this cycle
//   mixed      : InvMixColumns(state); holds its value across bubbles
module aes_inv_mix_cols
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [127:0] state,
  output logic         out_valid,
  output logic [127:0] mixed
);

  localparam int NUM_COLS = 4;

  // col_res[c] is column c; column 0 sits in the top word of the state.
  logic [NUM_COLS-1:0][31:0] col_res;

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    inv_mix_col_word u_col (
      .col_i (state[127-32*c -: 32]),
      .col_o (col_res[c])
    );
  end

  aes_state_t mixed_d, mixed_q;
  logic       out_valid_d, out_valid_q;

  always_comb begin
    out_valid_d = in_valid;
    mixed_d     = mixed_q;
    if (in_valid) mixed_d = {col_res[0], col_res[1], col_res[2], col_res[3]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      mixed_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      mixed_q     <= mixed_d;
    end
  end

  assign out_valid = out_valid_q;
  assign mixed     = mixed_q;

endmodule

// File: tb/tb_aes_inv_mix_cols.sv
module tb_aes_inv_mix_cols;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] state;
  logic         out_valid;
  logic [127:0] mixed;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] V1_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V1_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V2_IN  = 128'hd5d5d7d6_4d7ebdf8_00000000_c6c6c6c6;
  localparam logic [127:0] V2_OUT = 128'hd4d4d4d5_2d26314c_00000000_c6c6c6c6;

  aes_inv_mix_cols dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .state     (state),
    .out_valid (out_valid),
    .mixed     (mixed)
  );

  always #5 clk = ~clk;

  // Forward MixColumns reference, used to build inputs whose inverse is known.
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [31:0] fwd_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    a0 = w[31:24]; a1 = w[23:16]; a2 = w[15:8]; a3 = w[7:0];
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  function automatic logic [127:0] fwd_mix(input logic [127:0] s);
    return {fwd_col(s[127:96]), fwd_col(s[95:64]), fwd_col(s[63:32]), fwd_col(s[31:0])};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; state = 128'h0123456789abcdef_fedcba9876543210;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    n_cmp++;
    if (mixed !== 128'h0) begin n_bad++; $display("FAIL reset_mixed got=%h want=0", mixed); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL post_reset_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_vectors();
    in_valid = 1'b1; state = V1_IN;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || mixed !== V1_OUT) begin
      n_bad++; $display("FAIL vec1 got=%b/%h want=1/%h", out_valid, mixed, V1_OUT);
    end
    in_valid = 1'b0; state = V2_IN;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || mixed !== V1_OUT) begin
      n_bad++; $display("FAIL bubble_hold got=%b/%h want=0/%h", out_valid, mixed, V1_OUT);
    end
    in_valid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || mixed !== V2_OUT) begin
      n_bad++; $display("FAIL vec2 got=%b/%h want=1/%h", out_valid, mixed, V2_OUT);
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; state = V1_IN;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || mixed !== V1_OUT) begin
      n_bad++; $display("FAIL b2b_first got=%b/%h want=1/%h", out_valid, mixed, V1_OUT);
    end
    state = V2_IN;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || mixed !== V2_OUT) begin
      n_bad++; $display("FAIL b2b_second got=%b/%h want=1/%h", out_valid, mixed, V2_OUT);
    end
    in_valid = 1'b0; state = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || mixed !== V2_OUT) begin
      n_bad++; $display("FAIL b2b_drop got=%b/%h want=0/%h", out_valid, mixed, V2_OUT);
    end
  endtask

  task automatic test_corners();
    in_valid = 1'b1; state = {4{32'h80808080}};
    @(negedge clk);
    n_cmp++;
    if (mixed !== {4{32'h80808080}}) begin
      n_bad++; $display("FAIL corner_80 got=%h want=%h", mixed, {4{32'h80808080}});
    end
    state = {4{32'hffffffff}};
    @(negedge clk);
    n_cmp++;
    if (mixed !== {4{32'hffffffff}}) begin
      n_bad++; $display("FAIL corner_ff got=%h want=%h", mixed, {4{32'hffffffff}});
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_inverse();
    logic [127:0] s, exp_s;
    int bad_local;
    bad_local = 0;
    in_valid = 1'b1;
    s = {$urandom, $urandom, $urandom, $urandom};
    state = fwd_mix(s);
    for (int i = 0; i < 1000; i++) begin
      exp_s = s;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || mixed !== exp_s) begin
        n_bad++; bad_local++;
        if (bad_local <= 5) $display("FAIL inverse[%0d] got=%b/%h want=1/%h", i, out_valid, mixed, exp_s);
      end
      s = {$urandom, $urandom, $urandom, $urandom};
      state = fwd_mix(s);
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; state = V1_IN;
    @(posedge clk);
    #2;
    n_cmp++;
    if (out_valid !== 1'b1 || mixed !== V1_OUT) begin
      n_bad++; $display("FAIL pre_async got=%b/%h want=1/%h", out_valid, mixed, V1_OUT);
    end
    state = V2_IN;
    rst_n = 1'b0;  // between edges
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || mixed !== 128'h0) begin
      n_bad++; $display("FAIL async_reset got=%b/%h want=0/0", out_valid, mixed);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || mixed !== 128'h0) begin
      n_bad++; $display("FAIL async_release got=%b/%h want=0/0", out_valid, mixed);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_corners();
    test_inverse();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
